cci_mpf_prim_tx_buffer_multi: RTL and testbench
===============================================

Name: cci_mpf_prim_tx_buffer_multi

Overview:
- Parametrised N-channel, latency-insensitive request buffer for the AFU-side Tx path of MPF shims.
- Generalises the fixed two-channel c0/c1 buffering to N_CHANNELS independent FIFOs of arbitrary width and non-power-of-2 depth.
- Adds per-channel FIFO bypass masks, occupancy reporting and sticky overflow/underflow error flags.
- Sits between an AFU-facing raw request source and a shim's arbitration logic; the consumer removes heads explicitly with deq_en.

Parameters:
- N_CHANNELS, 2, number of independent request channels (>=1).
- N_DATA_BITS, 64, payload width per channel.
- THRESHOLD, 8, almostFull asserts when free slots <= THRESHOLD.
- N_ENTRIES, THRESHOLD+4, slots per channel. Need not be a power of 2. Elaboration error unless N_ENTRIES > THRESHOLD and N_ENTRIES >= 2.
- BYPASS_MASK, 1 (bit 0 only), bit i set lets channel i bypass its FIFO when empty.
- CNT_BITS, $clog2(N_ENTRIES+1), derived local width of occupancy fields.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_en  in  N_CHANNELS  per-channel request valid from the raw side.
- enq_data  in  N_CHANNELS*N_DATA_BITS  payloads; channel i is at [i*N_DATA_BITS +: N_DATA_BITS].
- almostFull  out  N_CHANNELS  per-channel back-pressure to the raw side.
- first  out  N_CHANNELS*N_DATA_BITS  head payload per channel.
- notEmpty  out  N_CHANNELS  per-channel head valid; includes the bypass case.
- deq_en  in  N_CHANNELS  consumer removes head of channel i.
- occupancy  out  N_CHANNELS*CNT_BITS  stored entries per channel; bypassed entries are not counted.
- overflow_err  out  N_CHANNELS  sticky: an enq was dropped on a full channel.
- underflow_err  out  N_CHANNELS  sticky: deq_en was asserted while notEmpty was 0.

Behaviour:
- Channels are fully independent; there is no cross-channel arbitration or ordering.
- Per-channel state:
  - wr_ptr and rd_ptr, 0..N_ENTRIES-1, wrapping explicitly from N_ENTRIES-1 to 0.
  - count, 0..N_ENTRIES.
  - Storage array: written on the clock edge, read asynchronously at rd_ptr.
- Reset (synchronous, any cycle, including mid-traffic):
  - Next cycle: pointers=0, count=0, overflow_err=0, underflow_err=0, notEmpty=0. All stored data is discarded.
  - almostFull is forced to 1 during every cycle in which reset=1.
  - enq_en and deq_en are ignored while reset=1.
- Outputs when not in reset:
  - almostFull[i] = (N_ENTRIES - count) <= THRESHOLD. This is decoded from registers only, with no combinational path from enq_en or deq_en.
  - occupancy[i] = count.
- No-bypass channel:
  - notEmpty = (count != 0); first = storage[rd_ptr].
  - Latency enq to notEmpty is 1 cycle.
- Bypass channel (BYPASS_MASK[i]=1) with count==0:
  - first = enq_data[i] and notEmpty = enq_en[i], combinationally (0-cycle latency).
  - If enq_en && deq_en in that cycle, the request is consumed directly: no store, count unchanged.
  - If enq_en && !deq_en, the request is stored and count becomes 1.
- Bypass channel with count != 0: behaves exactly as no-bypass. FIFO order is preserved.
- Count update, evaluated per cycle with the bypass case excluded:
  - Effective enq = enq_en && (count < N_ENTRIES || effective deq).
  - Effective deq = deq_en && count != 0.
  - count' = count + effective enq - effective deq.
  - Simultaneous enq and deq on a full FIFO is accepted; count stays N_ENTRIES.
- Overflow: enq_en with count==N_ENTRIES and no effective deq. The payload is dropped, count is unchanged, and overflow_err is set next cycle. It stays set until reset.
- Underflow: deq_en with notEmpty==0. No pointer change; underflow_err is set next cycle and stays set until reset.
- With a legal source that honours almostFull, at most THRESHOLD requests can follow the almostFull assertion, so overflow is never reached.

Test Plan:
- Reset then fill: after reset, push 4 entries on channel 1 (no deq) -> notEmpty[1]=1 one cycle after first enq, occupancy[1]=4, almostFull[1] rises exactly when occupancy reaches 4 (free=8), first[1] equals the first payload.
- Wrap and non-power-of-2 depth: N_ENTRIES=12; stream 40 entries with random deq gaps -> output order matches input, pointers wrap at 11->0, no errors.
- Bypass: on empty channel 0, enq 0xA5 with deq_en in the same cycle -> first[0]=0xA5 and notEmpty[0]=1 in that cycle, occupancy stays 0. Repeat on channel 1 -> no bypass, 1-cycle latency.
- Full boundary: fill channel 1 to 12; assert enq+deq together -> count stays 12, new data lands at tail. Then enq alone -> data dropped, overflow_err[1]=1 next cycle, channel 0 unaffected.
- Underflow: deq_en[0] on empty channel 0 -> underflow_err[0]=1 next cycle, occupancy stays 0.
- Mid-traffic reset: with 7 entries and both error flags set, assert reset 1 cycle -> almostFull=all ones during reset; next cycle occupancy=0, notEmpty=0, errors=0, and old data never reappears.

Source files
------------

// File: rtl/cci_mpf_prim_tx_buffer_multi.sv
// N-channel latency-insensitive Tx request buffer.
// Each channel is an independent FIFO with an arbitrary (non power-of-2) depth.
// Optional per-channel bypass lets a request reach the head combinationally
// when the FIFO is empty. Occupancy is reported per channel. Sticky
// overflow and underflow flags record illegal traffic until reset.
module cci_mpf_prim_tx_buffer_multi #(
  parameter int N_CHANNELS = 2,
  parameter int N_DATA_BITS = 64,
  parameter int THRESHOLD = 8,
  parameter int N_ENTRIES = THRESHOLD + 4,
  parameter logic [N_CHANNELS-1:0] BYPASS_MASK = N_CHANNELS'(1),
  localparam int CNT_BITS = $clog2(N_ENTRIES + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CHANNELS-1:0]             enq_en,
  input  logic [N_CHANNELS*N_DATA_BITS-1:0] enq_data,
  output logic [N_CHANNELS-1:0]             almostFull,
  output logic [N_CHANNELS*N_DATA_BITS-1:0] first,
  output logic [N_CHANNELS-1:0]             notEmpty,
  input  logic [N_CHANNELS-1:0]             deq_en,
  output logic [N_CHANNELS*CNT_BITS-1:0]    occupancy,
  output logic [N_CHANNELS-1:0]             overflow_err,
  output logic [N_CHANNELS-1:0]             underflow_err
);

  localparam int PTR_BITS = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  // Reject depths that cannot hold more than the back-pressure slack.
  if (!(N_ENTRIES > THRESHOLD && N_ENTRIES >= 2)) begin : g_param_check
    $error("cci_mpf_prim_tx_buffer_multi: N_ENTRIES must exceed THRESHOLD and be at least 2");
  end

  // Pointers wrap explicitly so any depth works, not just powers of 2.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(N_ENTRIES - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  genvar gi;
  for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
    logic [N_DATA_BITS-1:0] storage [N_ENTRIES];
    logic [PTR_BITS-1:0]    wr_ptr_reg;
    logic [PTR_BITS-1:0]    rd_ptr_reg;
    logic [CNT_BITS-1:0]    count_reg;
    logic                   overflow_reg;
    logic                   underflow_reg;
    logic [N_DATA_BITS-1:0] enq_word;
    logic                   is_empty;
    logic                   is_full;
    logic                   bypass_active;
    logic                   head_valid;
    logic                   eff_enq;
    logic                   eff_deq;

    assign enq_word      = enq_data[gi*N_DATA_BITS +: N_DATA_BITS];
    assign is_empty      = (count_reg == '0);
    assign is_full       = (count_reg == CNT_BITS'(N_ENTRIES));
    assign bypass_active = BYPASS_MASK[gi] && is_empty;
    assign head_valid    = bypass_active ? enq_en[gi] : !is_empty;
    assign eff_deq       = deq_en[gi] && !is_empty;
    // A bypassed request that is dequeued in the same cycle never gets stored.
    assign eff_enq       = enq_en[gi] && (!is_full || eff_deq)
                           && !(bypass_active && deq_en[gi]);

    // Payload storage: written on the edge, read asynchronously at the head.
    always_ff @(posedge clk) begin
      if (!reset && eff_enq) begin
        storage[wr_ptr_reg] <= enq_word;
      end
    end

    // Pointer, count and sticky error state.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (eff_enq) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (eff_deq) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        count_reg <= count_reg + CNT_BITS'(eff_enq) - CNT_BITS'(eff_deq);
        if (enq_en[gi] && is_full && !eff_deq) overflow_reg <= 1'b1;
        if (deq_en[gi] && !head_valid) underflow_reg <= 1'b1;
      end
    end

    assign first[gi*N_DATA_BITS +: N_DATA_BITS] =
      bypass_active ? enq_word : storage[rd_ptr_reg];
    assign notEmpty[gi]      = head_valid;
    // Decoded from the count register only; reset forces back-pressure.
    assign almostFull[gi]    = reset ||
      ((CNT_BITS'(N_ENTRIES) - count_reg) <= CNT_BITS'(THRESHOLD));
    assign occupancy[gi*CNT_BITS +: CNT_BITS] = count_reg;
    assign overflow_err[gi]  = overflow_reg;
    assign underflow_err[gi] = underflow_reg;
  end

endmodule

// File: tb/tb_cci_mpf_prim_tx_buffer_multi.sv
// Directed bench for the N-channel Tx buffer (2 channels, depth 12,
// threshold 8, bypass on channel 0 only).
module tb_cci_mpf_prim_tx_buffer_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   enq_en;
  logic [127:0] enq_data;
  logic [1:0]   almostFull;
  logic [127:0] first;
  logic [1:0]   notEmpty;
  logic [1:0]   deq_en;
  logic [7:0]   occupancy;
  logic [1:0]   overflow_err;
  logic [1:0]   underflow_err;

  int passed = 0;
  int total  = 0;

  cci_mpf_prim_tx_buffer_multi dut (
    .clk(clk),
    .reset(reset),
    .enq_en(enq_en),
    .enq_data(enq_data),
    .almostFull(almostFull),
    .first(first),
    .notEmpty(notEmpty),
    .deq_en(deq_en),
    .occupancy(occupancy),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q[$];
    int sent, rcvd, cyc;
    logic do_enq, do_deq;
    logic [63:0] exp_word;

    reset = 1'b1; enq_en = '0; deq_en = '0; enq_data = '0;
    tick();
    chk("af_during_reset", 64'(almostFull), 64'h3);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_not_empty", 64'(notEmpty), 64'h0);
    chk("rst_ovf", 64'(overflow_err), 64'h0);
    chk("rst_udf", 64'(underflow_err), 64'h0);
    chk("rst_af", 64'(almostFull), 64'h0);

    // Fill channel 1 with 4 entries
    for (int k = 0; k < 4; k++) begin
      enq_en = 2'b10; enq_data[127:64] = 64'hC10000 + 64'(k);
      #1;
      if (k == 0) chk("fill_no_bypass_ch1", 64'(notEmpty[1]), 64'h0);
      tick();
      enq_en = '0;
      chk("fill_not_empty", 64'(notEmpty[1]), 64'h1);
      chk("fill_occ", 64'(occupancy[7:4]), 64'(k + 1));
      chk("fill_af", 64'(almostFull[1]), (k + 1 >= 4) ? 64'h1 : 64'h0);
      chk("fill_head", first[127:64], 64'hC10000);
    end
    // Drain in order
    for (int k = 0; k < 4; k++) begin
      deq_en = 2'b10;
      #1;
      chk("drain_order", first[127:64], 64'hC10000 + 64'(k));
      tick();
    end
    deq_en = '0;
    #1;
    chk("drain_occ", 64'(occupancy[7:4]), 64'h0);
    chk("drain_not_empty", 64'(notEmpty[1]), 64'h0);

    // Bypass on channel 0: consumed directly
    enq_en = 2'b01; deq_en = 2'b01; enq_data[63:0] = 64'hA5;
    #1;
    chk("bypass_first", first[63:0], 64'hA5);
    chk("bypass_not_empty", 64'(notEmpty[0]), 64'h1);
    tick();
    enq_en = '0; deq_en = '0;
    #1;
    chk("bypass_occ", 64'(occupancy[3:0]), 64'h0);
    chk("bypass_not_empty_after", 64'(notEmpty[0]), 64'h0);
    chk("bypass_udf", 64'(underflow_err[0]), 64'h0);
    // Bypass enq without deq is stored
    enq_en = 2'b01; enq_data[63:0] = 64'h5A;
    tick();
    enq_en = '0;
    #1;
    chk("bypass_store_occ", 64'(occupancy[3:0]), 64'h1);
    chk("bypass_store_head", first[63:0], 64'h5A);
    deq_en = 2'b01;
    tick();
    deq_en = '0;
    #1;
    chk("bypass_store_drained", 64'(occupancy[3:0]), 64'h0);
    // Channel 1 has no bypass: 1-cycle latency
    enq_en = 2'b10; enq_data[127:64] = 64'hB6;
    #1;
    chk("ch1_latency_0", 64'(notEmpty[1]), 64'h0);
    tick();
    enq_en = '0;
    chk("ch1_latency_1", 64'(notEmpty[1]), 64'h1);
    chk("ch1_head", first[127:64], 64'hB6);
    deq_en = 2'b10;
    tick();
    deq_en = '0;
    #1;
    chk("ch1_drained", 64'(occupancy[7:4]), 64'h0);

    // Stream 40 entries through channel 1 with random deq gaps
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 40 || rcvd < 40) && cyc < 2000) begin
      do_enq = (sent < 40) && !almostFull[1] && ($urandom_range(0, 3) != 0);
      do_deq = notEmpty[1] && ($urandom_range(0, 2) != 0);
      enq_en = {do_enq, 1'b0}; deq_en = {do_deq, 1'b0};
      enq_data[127:64] = 64'hD000 + 64'(sent);
      #1;
      if (do_deq) begin
        exp_word = (q.size() != 0) ? q[0] : 64'hFFFF_FFFF;
        chk("stream_order", first[127:64], exp_word);
      end
      tick();
      if (do_enq) begin
        q.push_back(64'hD000 + 64'(sent));
        sent++;
      end
      if (do_deq) begin
        if (q.size() != 0) void'(q.pop_front());
        rcvd++;
      end
      cyc++;
    end
    enq_en = '0; deq_en = '0;
    #1;
    chk("stream_received", 64'(rcvd), 64'd40);
    chk("stream_occ", 64'(occupancy[7:4]), 64'h0);
    chk("stream_ovf", 64'(overflow_err), 64'h0);
    chk("stream_udf", 64'(underflow_err), 64'h0);

    // Full boundary on channel 1
    for (int k = 0; k < 12; k++) begin
      enq_en = 2'b10; enq_data[127:64] = 64'hF00 + 64'(k);
      tick();
    end
    enq_en = '0;
    #1;
    chk("full_occ", 64'(occupancy[7:4]), 64'd12);
    chk("full_af", 64'(almostFull[1]), 64'h1);
    enq_en = 2'b10; deq_en = 2'b10; enq_data[127:64] = 64'hAAA;
    #1;
    chk("full_swap_head", first[127:64], 64'hF00);
    tick();
    enq_en = '0; deq_en = '0;
    #1;
    chk("full_swap_occ", 64'(occupancy[7:4]), 64'd12);
    chk("full_swap_next", first[127:64], 64'hF01);
    chk("full_swap_no_ovf", 64'(overflow_err[1]), 64'h0);
    enq_en = 2'b10; enq_data[127:64] = 64'hDEAD;
    tick();
    enq_en = '0;
    #1;
    chk("ovf_set", 64'(overflow_err[1]), 64'h1);
    chk("ovf_occ", 64'(occupancy[7:4]), 64'd12);
    chk("ovf_ch0_clean", 64'(overflow_err[0]), 64'h0);
    chk("ovf_ch0_occ", 64'(occupancy[3:0]), 64'h0);
    for (int k = 0; k < 12; k++) begin
      deq_en = 2'b10;
      #1;
      chk("full_drain_order", first[127:64], (k < 11) ? 64'hF01 + 64'(k) : 64'hAAA);
      tick();
    end
    deq_en = '0;
    #1;
    chk("full_drained", 64'(occupancy[7:4]), 64'h0);
    chk("full_ovf_sticky", 64'(overflow_err[1]), 64'h1);
    chk("full_no_udf", 64'(underflow_err[1]), 64'h0);

    // Underflow on empty channel 0
    deq_en = 2'b01;
    tick();
    deq_en = '0;
    #1;
    chk("udf_set", 64'(underflow_err[0]), 64'h1);
    chk("udf_occ", 64'(occupancy[3:0]), 64'h0);
    chk("udf_ch1_clean", 64'(underflow_err[1]), 64'h0);

    // Mid-traffic reset with 7 entries and both flags set
    for (int k = 0; k < 7; k++) begin
      enq_en = 2'b10; enq_data[127:64] = 64'hE00 + 64'(k);
      tick();
    end
    enq_en = '0;
    #1;
    chk("pre_rst_occ", 64'(occupancy[7:4]), 64'd7);
    reset = 1'b1; enq_en = 2'b11; deq_en = 2'b11;
    #1;
    chk("mid_rst_af", 64'(almostFull), 64'h3);
    tick();
    reset = 1'b0; enq_en = '0; deq_en = '0;
    #1;
    chk("post_rst_occ", 64'(occupancy), 64'h0);
    chk("post_rst_not_empty", 64'(notEmpty), 64'h0);
    chk("post_rst_ovf", 64'(overflow_err), 64'h0);
    chk("post_rst_udf", 64'(underflow_err), 64'h0);
    chk("post_rst_af", 64'(almostFull), 64'h0);
    enq_en = 2'b10; enq_data[127:64] = 64'h777;
    tick();
    enq_en = '0;
    #1;
    chk("post_rst_new_head", first[127:64], 64'h777);
    chk("post_rst_new_occ", 64'(occupancy[7:4]), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
